// File: rtl/vec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_seq_pkg
// Brief    : Shared sequencer state encoding and ALU opcode constants.
// Revision : 1.0 - initial release
// ============================================================================
package vec_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam logic [2:0] c_OP_ADD    = 3'b000;
    localparam logic [2:0] c_OP_SUB    = 3'b001;
    localparam logic [2:0] c_OP_PASS_A = 3'b110;
    localparam logic [2:0] c_OP_PASS_B = 3'b111;

endpackage
`default_nettype wire

// File: rtl/vec_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vec_alu_sequencer
// Brief    : Streams vector elements through an external combinational ALU,
//            one element per cycle. Flag accumulation: VEC_SEQ_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vec_alu_sequencer
    import vec_seq_pkg::*;
#(
    parameter int WIDTH    = 48,
    parameter int NUM_ELEM = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [2:0]                    op_sel,
    input  logic [NUM_ELEM*WIDTH-1:0]     vec_a,
    input  logic [NUM_ELEM*WIDTH-1:0]     vec_b,
    input  logic [$clog2(NUM_ELEM):0]     vec_len,
    output logic [WIDTH-1:0]              alu_a,
    output logic [WIDTH-1:0]              alu_b,
    output logic [2:0]                    alu_sel,
    input  logic [WIDTH-1:0]              alu_out,
    input  logic                          alu_n,
    input  logic                          alu_z,
    input  logic                          alu_v,
    input  logic                          alu_c,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [NUM_ELEM*WIDTH-1:0]     vec_res,
    output logic                          flag_n,
    output logic                          flag_z,
    output logic                          flag_v,
    output logic                          flag_c,
    output logic                          busy
);

    localparam int c_LEN_W = $clog2(NUM_ELEM) + 1;
    localparam int c_VEC_W = NUM_ELEM * WIDTH;

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;
    logic [2:0]           r_op;
    logic [c_VEC_W-1:0]   r_a;
    logic [c_VEC_W-1:0]   r_b;
    logic [c_VEC_W-1:0]   r_res;
    logic [c_VEC_W-1:0]   w_res_nxt;
    logic [c_LEN_W-1:0]   r_len;
    logic [c_LEN_W-1:0]   r_idx;
    logic [c_LEN_W-1:0]   w_eff_len;
    logic                 w_accept;
    logic                 w_run;
    logic                 w_last;

    // Zero or out-of-range lengths request a full vector.
    always_comb begin
        w_eff_len = vec_len;
        if ((vec_len == '0) || (vec_len > c_LEN_W'(NUM_ELEM))) begin
            w_eff_len = c_LEN_W'(NUM_ELEM);
        end
    end

    assign w_accept = (r_state == ST_IDLE) && start_valid;
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = (r_idx == (r_len - c_LEN_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Element select toward the ALU and write-back of its result.
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = c_OP_PASS_A;
        w_res_nxt = r_res;
        if (w_run) begin
            alu_sel = r_op;
            for (int i = 0; i < NUM_ELEM; i++) begin
                if (r_idx == c_LEN_W'(i)) begin
                    alu_a                      = r_a[i*WIDTH +: WIDTH];
                    alu_b                      = r_b[i*WIDTH +: WIDTH];
                    w_res_nxt[i*WIDTH +: WIDTH] = alu_out;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= c_OP_PASS_A;
            r_a   <= '0;
            r_b   <= '0;
            r_len <= '0;
            r_idx <= '0;
            r_res <= '0;
        end else if (w_accept) begin
            r_op  <= op_sel;
            r_a   <= vec_a;
            r_b   <= vec_b;
            r_len <= w_eff_len;
            r_idx <= '0;
            r_res <= '0;
        end else if (w_run) begin
            r_idx <= r_idx + c_LEN_W'(1);
            r_res <= w_res_nxt;
        end
    end

    assign vec_res = r_res;

`ifdef VEC_SEQ_FLAGS_EN
    logic r_flag_n;
    logic r_flag_z;
    logic r_flag_v;
    logic r_flag_c;

    // The first element seeds the accumulators so flag_z starts from alu_z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (w_accept) begin
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (w_run) begin
            r_flag_n <= alu_n;
            if (r_idx == '0) begin
                r_flag_z <= alu_z;
                r_flag_v <= alu_v;
                r_flag_c <= alu_c;
            end else begin
                r_flag_z <= r_flag_z & alu_z;
                r_flag_v <= r_flag_v | alu_v;
                r_flag_c <= r_flag_c | alu_c;
            end
        end
    end

    assign flag_n = r_flag_n;
    assign flag_z = r_flag_z;
    assign flag_v = r_flag_v;
    assign flag_c = r_flag_c;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{alu_n, alu_z, alu_v, alu_c};
    assign flag_n = 1'b0;
    assign flag_z = 1'b0;
    assign flag_v = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule
`default_nettype wire
